arb4_select: RTL

Four-way round-robin arbiter that drives the 2-bit `select` of the `mux4` data stage directly downstream. It watches four requester valid lines, grants one requester at a time, and holds the grant while that requester's data flows through `mux4`. It completes a valid/ready handshake with the consumer behind the mux. Fairness comes from a rotating priority pointer, and a bounded burst length prevents one requester from starving the others.

---
 rtl/arb4_pkg.sv | 14 +
 rtl/rr_pick4.sv | 29 ++
 rtl/arb4_select.sv | 99 +++++++++
 3 files changed

// File: rtl/arb4_pkg.sv
// Shared types and sizes for the four-way round-robin select arbiter.
package arb4_pkg;

  typedef enum logic {S_IDLE, S_GRANT} arb_state_t;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned SEL_W   = 2;

  // One-hot decode of a requester index.
  function automatic logic [NUM_REQ-1:0] onehot4(input logic [SEL_W-1:0] idx);
    return NUM_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Rotating-priority picker: first set request scanning base, base+1, ... (mod 4).
module rr_pick4
  import arb4_pkg::*;
(
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [SEL_W-1:0]   i_base,
  output logic [SEL_W-1:0]   o_idx,
  output logic               o_any
);

  logic [2*NUM_REQ-1:0] w_dbl;
  logic [NUM_REQ-1:0]   w_rot;
  logic [SEL_W-1:0]     w_off;

  // Doubling the vector turns the rotate into a plain part-select.
  assign w_dbl = {i_req, i_req};
  assign w_rot = w_dbl[i_base +: NUM_REQ];

  always_comb begin
    w_off = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (w_rot[i]) w_off = SEL_W'(i);
    end
  end

  assign o_idx = i_base + w_off;
  assign o_any = |i_req;

endmodule

// File: rtl/arb4_select.sv
// Four-way round-robin arbiter driving mux4.select, with bounded bursts per grant.
module arb4_select
  import arb4_pkg::*;
#(
  parameter int unsigned MAX_BURST = 1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [NUM_REQ-1:0] i_req_valid,
  output logic [NUM_REQ-1:0] o_req_ready,
  output logic [SEL_W-1:0]   o_select,
  output logic [NUM_REQ-1:0] o_grant,
  output logic               o_out_valid,
  input  logic               i_out_ready,
  output logic               o_busy
);

  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

  arb_state_t         r_state, w_state_nxt;
  logic [SEL_W-1:0]   r_ptr, w_ptr_nxt;
  logic [SEL_W-1:0]   r_gidx, w_gidx_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [NUM_REQ-1:0] r_grant, w_grant_nxt;

  logic [SEL_W-1:0]   w_pick;
  logic               w_any;
  logic               w_cur_valid;
  logic               w_xfer;
  logic               w_last;

  rr_pick4 u_pick (
    .i_req  (i_req_valid),
    .i_base (r_ptr),
    .o_idx  (w_pick),
    .o_any  (w_any)
  );

  // Handshake is combinational so a transfer costs no register latency.
  assign w_cur_valid = i_req_valid[r_gidx];
  assign o_out_valid = (r_state == S_GRANT) && w_cur_valid;
  assign w_xfer      = o_out_valid && i_out_ready;
  assign o_req_ready = w_xfer ? onehot4(r_gidx) : '0;
  assign w_last      = (r_cnt == CNT_W'(MAX_BURST - 1));

  assign o_select = r_gidx;
  assign o_grant  = r_grant;
  assign o_busy   = (r_state == S_GRANT);

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_gidx_nxt  = r_gidx;
    w_cnt_nxt   = r_cnt;
    w_grant_nxt = r_grant;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_state_nxt = S_GRANT;
          w_gidx_nxt  = w_pick;
          w_cnt_nxt   = '0;
          w_grant_nxt = onehot4(w_pick);
        end
      end
      S_GRANT: begin
        // Release on a dropped request or on the final transfer of the burst.
        if (!w_cur_valid || (w_xfer && w_last)) begin
          w_state_nxt = S_IDLE;
          w_ptr_nxt   = r_gidx + SEL_W'(1);
          w_cnt_nxt   = '0;
          w_grant_nxt = '0;
        end else if (w_xfer) begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_grant_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_gidx  <= '0;
      r_cnt   <= '0;
      r_grant <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_gidx  <= w_gidx_nxt;
      r_cnt   <= w_cnt_nxt;
      r_grant <= w_grant_nxt;
    end
  end

endmodule
